mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the pipelined Dadda-tree `multiplier`, inside the EX-stage M-extension unit.
- Accepts one RV32M multiply request through a valid/ready handshake and holds the operands and funct3 stable at the multiplier for its full latency.
- Captures the 64-bit product, applies the MULHSU correction, selects the low or high word, and holds the result until the writeback side accepts it.
- Supports flush from the pipeline.

Parameters:
- LATENCY, 3, clock edges from operands first presented on mul_rs1/mul_rs2 to mul_product being valid. Legal values ≥ 1.
- CNT_W, 3, counter width. Must satisfy 2^CNT_W > LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight or held operation
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu
- req_rs1  in  32  operand A
- req_rs2  in  32  operand B
- req_rd  in  5  destination tag
- mul_rs1  out  32  to multiplier rs1_data
- mul_rs2  out  32  to multiplier rs2_data
- mul_funct3  out  3  to multiplier funct3
- mul_product  in  64  from multiplier mul_out
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_data  out  32  selected result word
- resp_rd  out  5  tag of the result
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset is synchronous on rst. Every output and register returns to its reset value at that edge, including mid-operation:
  - state IDLE, cnt 0
  - mul_rs1, mul_rs2 = 0; mul_funct3 = 000
  - resp_valid = 0, resp_data = 0, resp_rd = 0, busy = 0
  - req_ready = 1 in the first cycle after the reset edge
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid && !flush: latch operands, tag and funct3; load cnt=LATENCY; go BUSY.
  - BUSY: req_ready=0. Decrement cnt each edge while cnt≠0. At the edge where cnt==0: capture the result into resp_data/resp_rd and go DONE.
  - DONE: resp_valid=1 and req_ready=resp_ready.
    - resp_ready && req_valid: accept the new request in the same edge (back-to-back) and go BUSY.
    - resp_ready && !req_valid: go IDLE.
    - !resp_ready: hold resp_data, resp_rd and resp_valid unchanged.
- Flush has priority over everything except rst. Any state goes to IDLE at the next edge; resp_valid is 0 the following cycle. A request presented in the flush cycle is not accepted, and req_ready is driven 0 in a flush cycle.
- Operands: mul_rs1, mul_rs2 and mul_funct3 are registered. They change only at an accept edge and stay constant through BUSY and DONE, because the multiplier samples funct3 combinationally after its first stage.
- funct3 mapping to the multiplier:
  - mulhu → 000 (unsigned path)
  - mul → 000
  - mulh → 001 (signed path)
  - mulhsu → 001 (signed path)
- Result selection is computed from mul_product in the cnt==0 cycle:
  - mul: mul_product[31:0]
  - mulh: mul_product[63:32]
  - mulhu: mul_product[63:32]
  - mulhsu: mul_product[63:32] + (mul_rs2[31] ? mul_rs1 : 0), mod 2^32. This converts the signed×signed product into signed×unsigned.
  - funct3[2]=1: the request is accepted and completes normally with resp_data = 0.
- Latency: a request accepted at edge E0 has resp_valid=1 in the cycle after edge E0+LATENCY+1, i.e. 4 cycles with the default LATENCY.
- Throughput: one operation per LATENCY+1 cycles with resp_ready held high.
- busy is a combinational decode of the state.

Test Plan:
- mul: rs1=7, rs2=6 → resp_data=0x0000002A, resp_rd echoes the tag, resp_valid exactly 4 cycles after accept, req_ready=0 during BUSY.
- Signed, unsigned and edge cases:
  - mulh rs1=0xFFFFFFFE, rs2=3 → 0xFFFFFFFF
  - mulh rs1=0x80000000, rs2=0x80000000 → 0x40000000
  - mulhu rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFE; mul_funct3 observed = 000
- mulhsu rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF; mulhsu rs1=2, rs2=0x80000000 → 0x00000001.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_data and resp_valid stable, mul_rs1 unchanged. Then raise resp_ready together with a new req_valid → handshake on the same edge, new result 4 cycles later.
- Flush at cnt==1, and separately flush in DONE while resp_ready=0 → IDLE next edge, no resp_valid pulse, and a request in the flush cycle is not accepted.
- Assert rst mid-BUSY → all outputs at reset values the next cycle and req_ready=1. A following mul 3×5 returns 0x0000000F with the correct latency.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences one RV32M multiply through the pipelined multiplier and holds the selected result for writeback.
module mul_issue_ctrl #(
  parameter int LATENCY = 3,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  output logic [2:0]  mul_funct3,
  input  logic [63:0] mul_product,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3;
  logic [4:0] rd;
  logic acc, fin;
  logic [31:0] hi, res;
  always_comb begin
    req_ready = !flush && (state == IDLE || (state == DONE && resp_ready));
    acc = req_valid && req_ready;
    fin = state == BUSY && cnt == '0;
    resp_valid = state == DONE;
    busy = state != IDLE;
    // signed x signed high word becomes signed x unsigned by adding rs1 when rs2 is negative
    hi = mul_product[63:32] + ((f3 == 3'b010 && mul_rs2[31]) ? mul_rs1 : 32'd0);
    res = f3[2] ? 32'd0 : (f3[1:0] == 2'b00) ? mul_product[31:0] : hi;
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (acc) state_nx = BUSY;
    else if (fin) state_nx = DONE;
    else if (state == DONE && resp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mul_rs1 <= '0;
      mul_rs2 <= '0;
      mul_funct3 <= '0;
      f3 <= '0;
      rd <= '0;
      resp_data <= '0;
      resp_rd <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        mul_rs1 <= req_rs1;
        mul_rs2 <= req_rs2;
        mul_funct3 <= {2'b00, req_funct3 == 3'b001 || req_funct3 == 3'b010};
        f3 <= req_funct3;
        rd <= req_rd;
        cnt <= CNT_W'(LATENCY);
      end else if (flush) cnt <= '0;
      else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (fin && !flush) begin
        resp_data <= res;
        resp_rd <= rd;
      end
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: scoreboard bench with a behavioural multiplier and arithmetic reference model.
module tb_mul_issue_ctrl;
  localparam int LAT = 3;
  logic clk = 0, rst = 1, flush = 0, req_valid = 0, resp_ready = 1;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0;
  logic [4:0] req_rd = 0;
  logic req_ready, resp_valid, busy;
  logic [31:0] mul_rs1, mul_rs2, resp_data;
  logic [2:0] mul_funct3;
  logic [4:0] resp_rd;
  logic [63:0] mul_product;
  logic [63:0] pipe [LAT];
  int cyc = 0, total = 0, bad = 0;
  bit rr_rand = 0, shown = 0;
  typedef struct {logic [31:0] d; logic [4:0] rd; int due;} ent_t;
  ent_t q[$];

  mul_issue_ctrl #(.LATENCY(LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_funct3(mul_funct3), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pipelined multiplier: funct3 001 signed x signed, otherwise unsigned x unsigned
  always @(posedge clk) begin
    pipe[0] <= mul_funct3 == 3'b001
      ? 64'($signed({{32{mul_rs1[31]}}, mul_rs1}) * $signed({{32{mul_rs2[31]}}, mul_rs2}))
      : {32'b0, mul_rs1} * {32'b0, mul_rs2};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_product = pipe[LAT-1];

  always @(posedge clk) if (rr_rand) begin #1 resp_ready = 1'($urandom_range(0, 1)); end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ub = $signed({32'b0, b});
    if (f[2]) return 32'd0;
    case (f[1:0])
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return f[1:0] == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // monitor: response must appear exactly at its due cycle, hold until taken
  always @(negedge clk) begin
    bit exp_v;
    if (!rst) begin
      if (busy && !resp_valid) chk("ready_in_busy", req_ready, 0);
      exp_v = q.size() > 0 && cyc == q[0].due;
      if (!shown) begin
        chk("valid_timing", resp_valid, exp_v);
        if (exp_v) begin
          chk("resp_data", resp_data, q[0].d);
          chk("resp_rd", resp_rd, q[0].rd);
          if (resp_valid) shown = 1;
          else void'(q.pop_front());
        end
      end else begin
        chk("valid_hold", resp_valid, 1);
        chk("data_hold", resp_data, q[0].d);
      end
      if (shown && resp_valid && resp_ready) begin
        void'(q.pop_front());
        shown = 0;
      end
    end
    if (rst || flush) begin
      q.delete();
      shown = 0;
    end
  end

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, output int tries);
    bit ok;
    ent_t e;
    ok = 0;
    tries = 0;
    req_valid = 1; req_funct3 = f; req_rs1 = a; req_rs2 = b; req_rd = rd;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = req_ready;
      if (ok) begin
        e.d = exp; e.rd = rd; e.due = cyc + LAT + 2;
        q.push_back(e);
      end
      tries++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (!ok) chk("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!resp_valid) chk("valid_timeout", resp_valid, 1);
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_resp_rd"}, resp_rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_rs1"}, mul_rs1, 0);
    chk({tag, "_mul_rs2"}, mul_rs2, 0);
    chk({tag, "_mul_funct3"}, mul_funct3, 0);
  endtask

  initial begin
    int t;
    logic [2:0] f;
    logic [31:0] a, b;
    logic [4:0] rd;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset("rst");
    @(posedge clk); #1;
    // directed results, checked against hand-derived constants
    send(3'b000, 32'd7, 32'd6, 5'd5, 32'h0000_002A, t);
    wait_idle();
    send(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd1, 32'hFFFF_FFFF, t);
    send(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, t);
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, t);
    chk("mulhu_mul_funct3", mul_funct3, 3'b000);
    send(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, t);
    chk("mulhsu_mul_funct3", mul_funct3, 3'b001);
    send(3'b010, 32'd2, 32'h8000_0000, 5'd6, 32'h0000_0001, t);
    send(3'b101, 32'd9, 32'd9, 5'd7, 32'h0, t);
    wait_idle();
    // backpressure, then handshake and new accept on the same edge
    resp_ready = 0;
    send(3'b000, 32'h1234, 32'h10, 5'd9, 32'h0001_2340, t);
    wait_rv();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 32'h0001_2340);
      chk("bp_rs1", mul_rs1, 32'h1234);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    send(3'b000, 32'd11, 32'd11, 5'd10, 32'd121, t);
    chk("b2b_first_try", t, 1);
    wait_idle();
    // flush at cnt==1 with a competing request
    send(3'b000, 32'd4, 32'd4, 5'd11, 32'd16, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1; req_valid = 1; req_funct3 = 0; req_rs1 = 1; req_rs2 = 1; req_rd = 12;
    @(negedge clk);
    chk("flush_busy_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_busy_idle", busy, 0);
      chk("flush_busy_nov", resp_valid, 0);
    end
    // flush while holding a result under backpressure
    @(posedge clk); #1;
    resp_ready = 0;
    send(3'b001, 32'd3, 32'd3, 5'd13, 32'd0, t);
    wait_rv();
    flush = 1; req_valid = 1;
    @(negedge clk);
    chk("flush_done_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0; resp_ready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_done_nov", resp_valid, 0);
      chk("flush_done_idle", busy, 0);
    end
    // reset in the middle of an operation
    @(posedge clk); #1;
    send(3'b010, 32'd5, 32'd7, 5'd14, 32'd0, t);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset("midrst");
    @(posedge clk); #1;
    send(3'b000, 32'd3, 32'd5, 5'd15, 32'h0000_000F, t);
    wait_idle();
    // randomized traffic against the reference model
    rr_rand = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      rd = 5'($urandom_range(0, 31));
      send(f, a, b, rd, ref_res(f, a, b), t);
    end
    rr_rand = 0;
    @(posedge clk); #2;
    resp_ready = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1 chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
